// File: rtl/fb_pkg.sv
// Frame-buffer geometry and control-FSM state encoding, shared by the VGA top,
// the game FSM and the rectangle fill controller.
package fb_pkg;

    localparam int SCREEN_W = 265;
    localparam int SCREEN_H = 265;
    localparam int AW       = 17;
    localparam int DW       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } fb_state_e;

endpackage

// File: rtl/fb_addr_gen.sv
// Column/row walker over a rectangle [x0,xe) x [y0,ye) producing the linear
// frame-buffer address incrementally; the row base only ever adds SCREEN_W.
module fb_addr_gen #(
    parameter int SCREEN_W = 265,
    parameter int AW       = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [9:0]    x0,
    input  logic [9:0]    y0,
    input  logic [9:0]    xe,
    input  logic [9:0]    ye,
    output logic [AW-1:0] addr,
    output logic          frame_end
);

    localparam logic [AW-1:0] ROW_STEP = AW'(SCREEN_W);

    logic [9:0]    col;
    logic [9:0]    row;
    logic [9:0]    x_start;
    logic [9:0]    x_end;
    logic [9:0]    y_end;
    logic [AW-1:0] row_base;
    logic          row_end;

    assign row_end   = (col == x_end - 10'd1);
    assign frame_end = row_end && (row == y_end - 10'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col      <= '0;
            row      <= '0;
            x_start  <= '0;
            x_end    <= '0;
            y_end    <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (load) begin
            // Product with a constant: the starting row base only, never per pixel.
            col      <= x0;
            row      <= y0;
            x_start  <= x0;
            x_end    <= xe;
            y_end    <= ye;
            row_base <= AW'(y0) * ROW_STEP;
            addr     <= AW'(y0) * ROW_STEP + AW'(x0);
        end else if (step) begin
            if (row_end) begin
                col      <= x_start;
                row      <= row + 10'd1;
                row_base <= row_base + ROW_STEP;
                addr     <= row_base + ROW_STEP + AW'(x_start);
            end else begin
                col  <= col + 10'd1;
                addr <= addr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/rect_fill_ctrl.sv
// Rectangle fill / full clear engine writing one pixel per cycle into the frame buffer.
// Optional RECT_FILL_VBLANK_SYNC_EN adds a vblank input that gates operation start.
module rect_fill_ctrl #(
    parameter int SCREEN_W = fb_pkg::SCREEN_W,
    parameter int SCREEN_H = fb_pkg::SCREEN_H,
    parameter int AW       = fb_pkg::AW,
    parameter int DW       = fb_pkg::DW,
    parameter logic [DW-1:0] CLEAR_COLOR = '0
) (
    input  logic          clk,
    input  logic          rst,
`ifdef RECT_FILL_VBLANK_SYNC_EN
    input  logic          vblank,
`endif
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [8:0]    cmd_x,
    input  logic [8:0]    cmd_y,
    input  logic [8:0]    cmd_w,
    input  logic [8:0]    cmd_h,
    input  logic [DW-1:0] cmd_color,
    input  logic          clear_req,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic [1:0]    state_dbg
);

    import fb_pkg::*;

    localparam logic [9:0] W10 = 10'(SCREEN_W);
    localparam logic [9:0] H10 = 10'(SCREEN_H);

    fb_state_e  state, state_next;
    logic       alive;
    logic       go_ok;
    logic       start_clear, accept, empty, load, step, frame_end;
    logic [9:0] x_sum, y_sum, xe, ye;
    logic [9:0] ld_x0, ld_y0, ld_xe, ld_ye;

`ifdef RECT_FILL_VBLANK_SYNC_EN
    assign go_ok = vblank;
`else
    assign go_ok = 1'b1;
`endif

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready
    // and clear_req is low; a clear request in the same cycle wins and the command
    // is left untaken. cmd_ready depends only on state, never on cmd_valid.
    assign start_clear = cmd_ready & clear_req;
    assign accept      = cmd_ready & cmd_valid & ~clear_req;

    assign x_sum = {1'b0, cmd_x} + {1'b0, cmd_w};
    assign y_sum = {1'b0, cmd_y} + {1'b0, cmd_h};
    assign xe    = (x_sum > W10) ? W10 : x_sum;
    assign ye    = (y_sum > H10) ? H10 : y_sum;
    assign empty = ({1'b0, cmd_x} >= xe) || ({1'b0, cmd_y} >= ye);

    assign load  = start_clear | (accept & ~empty);
    assign step  = ((state == ST_FILL) || (state == ST_CLEAR)) && !frame_end;
    assign ld_x0 = start_clear ? 10'd0 : {1'b0, cmd_x};
    assign ld_y0 = start_clear ? 10'd0 : {1'b0, cmd_y};
    assign ld_xe = start_clear ? W10   : xe;
    assign ld_ye = start_clear ? H10   : ye;

    fb_addr_gen #(
        .SCREEN_W (SCREEN_W),
        .AW       (AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .x0        (ld_x0),
        .y0        (ld_y0),
        .xe        (ld_xe),
        .ye        (ld_ye),
        .addr      (mem_px_addr),
        .frame_end (frame_end)
    );

    // alive holds cmd_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            alive       <= 1'b0;
            mem_px_data <= '0;
        end else begin
            state <= state_next;
            alive <= 1'b1;
            if (start_clear) begin
                mem_px_data <= CLEAR_COLOR;
            end else if (accept && !empty) begin
                mem_px_data <= cmd_color;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_clear) begin
                    state_next = ST_CLEAR;
                end else if (accept) begin
                    state_next = empty ? ST_DONE : ST_FILL;
                end
            end
            ST_CLEAR, ST_FILL: begin
                if (frame_end) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE) && alive && go_ok;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        px_wr     = (state == ST_FILL) || (state == ST_CLEAR);
        state_dbg = state;
    end

endmodule

// File: tb/tb_rect_fill_ctrl.sv
// Bench for rect_fill_ctrl: vector table, random commands against a geometric
// reference model, and hand sequences for clear, reset and vblank gating.
module tb_rect_fill_ctrl;

    localparam int W  = 265;
    localparam int H  = 265;
    localparam int AW = 17;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
`ifdef RECT_FILL_VBLANK_SYNC_EN
    logic          vblank = 1'b1;
`endif
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [8:0]    cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic [DW-1:0] cmd_color = '0;
    logic          clear_req = 1'b0;
    logic          busy, done, px_wr;
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic [1:0]    state_dbg;

    rect_fill_ctrl dut (
        .clk         (clk),
        .rst         (rst),
`ifdef RECT_FILL_VBLANK_SYNC_EN
        .vblank      (vblank),
`endif
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_color   (cmd_color),
        .clear_req   (clear_req),
        .busy        (busy),
        .done        (done),
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .px_wr       (px_wr),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] got_addr[$];
    logic [DW-1:0] got_data[$];
    int            got_cyc[$];
    int            done_cnt   = 0;
    int            stable_err = 0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    bit            prev_ok = 0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_ok = 0;
        end else begin
            if (px_wr) begin
                got_addr.push_back(mem_px_addr);
                got_data.push_back(mem_px_data);
                got_cyc.push_back(cyc);
            end else if (prev_ok && (mem_px_addr !== prev_addr || mem_px_data !== prev_data)) begin
                stable_err++;
            end
            if (done) done_cnt++;
            prev_addr = mem_px_addr;
            prev_data = mem_px_data;
            prev_ok   = 1;
        end
    end

    // ---------------- reference model ----------------
    function automatic void build_exp(input int x, input int y, input int w, input int h);
        int xe, ye;
        xe = (x + w > W) ? W : x + w;
        ye = (y + h > H) ? H : y + h;
        for (int r = y; r < ye; r++)
            for (int c = x; c < xe; c++)
                exp_q.push_back(AW'(r * W + c));
    endfunction

    task automatic do_check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_got();
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
    endtask

    task automatic check_stream(input string name, input int acc, input logic [DW-1:0] col);
        int bad = -1;
        int lim;
        lim = (got_addr.size() < exp_q.size()) ? got_addr.size() : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            if (got_addr[i] !== exp_q[i] || got_data[i] !== col || got_cyc[i] != acc + 1 + i) begin
                bad = i;
                break;
            end
        end
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s_stream: entry %0d got addr %0d data %0d cycle %0d, expected addr %0d data %0d cycle %0d",
                     name, bad, got_addr[bad], got_data[bad], got_cyc[bad], exp_q[bad], col, acc + 1 + bad);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input int x, input int y, input int w, input int h, input int color,
                            output int acc, output bit ok);
        @(posedge clk); #1;
        cmd_x = 9'(x); cmd_y = 9'(y); cmd_w = 9'(w); cmd_h = 9'(h);
        cmd_color = DW'(color);
        cmd_valid = 1'b1;
        ok  = 0;
        acc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc;
                ok  = 1;
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (!ok) do_check("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(input int budget, output int dc, output bit ok);
        ok = 0;
        dc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                ok = 1;
                break;
            end
        end
        if (!ok) do_check("done_timeout", 0, 1);
    endtask

    task automatic run_fill(input int x, input int y, input int w, input int h, input int color,
                            input string tag, output int n, output int first, output int last);
        int acc, dc;
        bit ok;
        exp_q.delete();
        build_exp(x, y, w, h);
        clear_got();
        done_cnt = 0;
        n = -1; first = -1; last = -1;
        send_cmd(x, y, w, h, color, acc, ok);
        if (!ok) return;
        wait_done(exp_q.size() + 20, dc, ok);
        @(negedge clk);
        do_check({tag, "_ready_after"}, int'(cmd_ready), 1);
        do_check({tag, "_count"}, got_addr.size(), exp_q.size());
        check_stream(tag, acc, DW'(color));
        if (ok) do_check({tag, "_latency"}, dc - acc, exp_q.size() + 1);
        do_check({tag, "_done_pulses"}, done_cnt, 1);
        n = got_addr.size();
        if (n > 0) begin
            first = int'(got_addr[0]);
            last  = int'(got_addr[n-1]);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int x, y, w, h, color;
        int n, first, last;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n, first, last, acc, dc, rdy_seen, wcount;
        bit ok;

        vecs[0] = '{5,   3,   10,  2,   4, 20, 800,   1074};
        vecs[1] = '{260, 264, 10,  5,   2, 5,  70220, 70224};
        vecs[2] = '{7,   7,   0,   4,   1, 0,  -1,    -1};
        vecs[3] = '{7,   7,   4,   0,   1, 0,  -1,    -1};
        vecs[4] = '{300, 0,   5,   5,   3, 0,  -1,    -1};
        vecs[5] = '{0,   265, 5,   5,   5, 0,  -1,    -1};
        vecs[6] = '{0,   0,   1,   1,   7, 1,  0,     0};
        vecs[7] = '{264, 0,   511, 1,   6, 1,  264,   264};
        vecs[8] = '{0,   263, 3,   511, 5, 6,  69695, 69962};
        vecs[9] = '{511, 511, 511, 511, 2, 0,  -1,    -1};

        // reset state
        #2;
        do_check("rst_px_wr",     int'(px_wr), 0);
        do_check("rst_done",      int'(done), 0);
        do_check("rst_busy",      int'(busy), 0);
        do_check("rst_cmd_ready", int'(cmd_ready), 0);
        do_check("rst_addr",      int'(mem_px_addr), 0);
        do_check("rst_data",      int'(mem_px_data), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        do_check("ready_before_first_edge", int'(cmd_ready), 0);
        @(negedge clk);
        do_check("ready_after_first_edge", int'(cmd_ready), 1);

        // table-driven fills
        for (int i = 0; i < 10; i++) begin
            run_fill(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color,
                     $sformatf("vec%0d", i), n, first, last);
            do_check($sformatf("vec%0d_n", i), n, vecs[i].n);
            if (vecs[i].n > 0) begin
                do_check($sformatf("vec%0d_first", i), first, vecs[i].first);
                do_check($sformatf("vec%0d_last", i), last, vecs[i].last);
            end
        end

        // random fills against the model
        for (int r = 0; r < 24; r++) begin
            int x, y, w, h;
            x = $urandom_range(0, 280);
            y = $urandom_range(0, 280);
            w = $urandom_range(0, 12);
            h = $urandom_range(0, 12);
            if (r % 4 == 3) begin
                x = $urandom_range(250, 264);
                w = $urandom_range(0, 511);
            end
            run_fill(x, y, w, h, $urandom_range(0, 7), $sformatf("rnd%0d", r), n, first, last);
        end

        // reset at the 7th write of a fill
        send_cmd(5, 3, 10, 2, 4, acc, ok);
        wcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (px_wr) wcount++;
            if (wcount == 7) break;
        end
        do_check("midrst_reached_7th", wcount, 7);
        rst = 1'b0;
        #1;
        do_check("midrst_px_wr",     int'(px_wr), 0);
        do_check("midrst_busy",      int'(busy), 0);
        do_check("midrst_done",      int'(done), 0);
        do_check("midrst_cmd_ready", int'(cmd_ready), 0);
        do_check("midrst_addr",      int'(mem_px_addr), 0);
        clear_got();
        done_cnt = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        do_check("midrst_ready_before_edge", int'(cmd_ready), 0);
        @(negedge clk);
        do_check("midrst_ready_after_release", int'(cmd_ready), 1);
        repeat (30) @(negedge clk);
        do_check("midrst_no_writes", got_addr.size(), 0);
        do_check("midrst_no_done", done_cnt, 0);

        // clear with a simultaneous command
        exp_q.delete();
        build_exp(0, 0, W, H);
        clear_got();
        done_cnt = 0;
        rdy_seen = 0;
        @(posedge clk); #1;
        clear_req = 1'b1;
        cmd_valid = 1'b1;
        cmd_x = 9'd5; cmd_y = 9'd3; cmd_w = 9'd10; cmd_h = 9'd2; cmd_color = 3'b100;
        @(negedge clk);
        acc = cyc;
        do_check("clr_ready_at_request", int'(cmd_ready), 1);
        @(posedge clk); #1;
        clear_req = 1'b0;
        ok = 0;
        dc = 0;
        for (int i = 0; i < 71000; i++) begin
            @(negedge clk);
            if (cmd_ready) rdy_seen++;
            if (done) begin
                dc = cyc;
                ok = 1;
                break;
            end
        end
        if (!ok) do_check("clr_done_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        do_check("clr_ready_after", int'(cmd_ready), 1);
        do_check("clr_busy_after", int'(busy), 0);
        do_check("clr_count", got_addr.size(), W * H);
        check_stream("clr", acc, 3'b000);
        if (ok) do_check("clr_latency", dc - acc, W * H + 1);
        do_check("clr_ready_while_busy", rdy_seen, 0);
        do_check("clr_done_pulses", done_cnt, 1);
        repeat (5) @(negedge clk);
        do_check("clr_cmd_not_taken", got_addr.size(), W * H);
        do_check("clr_idle_after", int'(busy), 0);

`ifdef RECT_FILL_VBLANK_SYNC_EN
        // command offered outside vblank must wait; running op survives vblank fall
        begin
            int blocked = 0;
            exp_q.delete();
            build_exp(10, 10, 3, 1);
            clear_got();
            done_cnt = 0;
            @(posedge clk); #1;
            vblank = 1'b0;
            cmd_x = 9'd10; cmd_y = 9'd10; cmd_w = 9'd3; cmd_h = 9'd1; cmd_color = 3'b011;
            cmd_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (cmd_ready || busy) blocked++;
            end
            do_check("vb_no_accept_low", blocked, 0);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            vblank = 1'b1;
            send_cmd(10, 10, 3, 1, 3, acc, ok);
            vblank = 1'b0;
            wait_done(30, dc, ok);
            @(negedge clk);
            do_check("vb_count", got_addr.size(), 3);
            check_stream("vb", acc, 3'b011);
            do_check("vb_ready_low_outside", int'(cmd_ready), 0);
            vblank = 1'b1;
            @(negedge clk);
            do_check("vb_ready_back", int'(cmd_ready), 1);
        end
`endif

        do_check("addr_data_stable", stable_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_fill_ctrl.md
RECT_FILL_CTRL -- requirements
Module: rect_fill_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_W, default 265, frame-buffer width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 265, frame-buffer height in pixels.
REQ-003 SHALL have parameter AW, default 17, frame-buffer address width.
REQ-004 SHALL have parameter DW, default 3, pixel width (RGB 111).
REQ-005 SHALL have parameter CLEAR_COLOR, default 3'b000, colour written by a clear.
REQ-006 SHALL have port clk, input, 1, the single clock for the block; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1), the fill-command handshake.
REQ-009 SHALL have ports cmd_x, cmd_y, cmd_w and cmd_h, each input, 9 bits, giving the rectangle origin and size.
REQ-010 SHALL have port cmd_color, input, DW, the fill colour.
REQ-011 SHALL have port clear_req, input, 1, a request to clear the whole buffer.
REQ-012 SHALL have status outputs busy (1 bit) and done (1 bit, single-cycle pulse).
REQ-013 SHALL have write-port outputs mem_px_addr (AW), mem_px_data (DW) and px_wr (1), driving the buffer_ram_dp write side.

Function
REQ-014 SHALL implement states IDLE, CLEAR, FILL and DONE.
REQ-015 SHALL, in IDLE, assert cmd_ready=1 and busy=0; in every other state cmd_ready=0 and busy=1.
REQ-016 SHALL go from IDLE to CLEAR when clear_req=1; clear takes priority over a simultaneous cmd_valid, which is not accepted.
REQ-017 SHALL accept a command on cmd_valid&cmd_ready and go to FILL.
REQ-018 SHALL make the first px_wr occur in the cycle after acceptance, then write one pixel per cycle with no gaps.
REQ-019 SHALL compute the pixel address as x + y*SCREEN_W, with the row base advanced incrementally by SCREEN_W; no multiplier.
REQ-020 SHALL clip the fill to xe=min(cmd_x+cmd_w, SCREEN_W) and ye=min(cmd_y+cmd_h, SCREEN_H), using 10-bit sums, and write rows y..ye-1 and, within each, columns x..xe-1.
REQ-021 SHALL, when the clipped area is empty (w=0, h=0, x>=SCREEN_W or y>=SCREEN_H), go directly to DONE with no writes.
REQ-022 SHALL, in CLEAR, write CLEAR_COLOR to addresses 0..SCREEN_W*SCREEN_H-1 in ascending order.
REQ-023 SHALL enter DONE in the cycle after the last write, pulse done=1 for exactly one cycle, then return to IDLE.
REQ-024 SHALL keep mem_px_addr and mem_px_data stable and px_wr=0 whenever no write occurs.
REQ-025 SHALL ignore clear_req and cmd_* while not in IDLE; there is no queueing.

Reset
REQ-026 SHALL, on rst=0, immediately set state=IDLE, px_wr=0, done=0, busy=0, cmd_ready=0, mem_px_addr=0 and mem_px_data=0.
REQ-027 SHALL set cmd_ready=1 from the first clock edge after rst deasserts.
REQ-028 SHALL, when reset occurs mid-operation, abandon the operation with no further writes and no done pulse.

Configuration
REQ-029 SHALL support the macro RECT_FILL_VBLANK_SYNC_EN.
REQ-030 SHALL, when RECT_FILL_VBLANK_SYNC_EN is defined, add input vblank (1 bit) and start CLEAR/FILL only while vblank=1; cmd_ready = IDLE & vblank.
REQ-031 SHALL let an operation started under RECT_FILL_VBLANK_SYNC_EN run to completion even if vblank falls.
REQ-032 SHALL, when RECT_FILL_VBLANK_SYNC_EN is undefined, have no vblank port, with behaviour as in REQ-015..REQ-025.

Structure
REQ-033 SHALL place SCREEN_W, SCREEN_H, AW, DW and the state encoding in shared package fb_pkg, which is also used by the VGA top level and the game FSM.
REQ-034 SHALL instantiate one sub-module, fb_addr_gen: a column/row counter with incremental address generation and row-end/frame-end flags, reused by both CLEAR and FILL.

Verification
REQ-035 SHALL check: cmd (x=5, y=3, w=10, h=2, color=3'b100) -> 20 writes, addresses 800..809 then 1065..1074, data 3'b100, done 21 cycles after acceptance.
REQ-036 SHALL check: cmd (x=260, y=264, w=10, h=5) -> exactly 5 writes at addresses 70220..70224.
REQ-037 SHALL check: clear_req=1 -> 70225 writes of CLEAR_COLOR, addresses 0..70224 ascending, one done pulse.
REQ-038 SHALL check: cmd with w=0 -> no px_wr, done one cycle after acceptance, cmd_ready=1 the cycle after.
REQ-039 SHALL check: clear_req and cmd_valid together in IDLE -> CLEAR runs, the command is not accepted, and cmd_ready=0 until done.
REQ-040 SHALL check: rst=0 at the 7th write of the REQ-035 fill -> px_wr=0 immediately, no done pulse, cmd_ready=1 after release; with the macro defined, cmd_valid while vblank=0 -> no acceptance until vblank=1.
